// File: rtl/pipe_pkg.sv
// Shared definitions for elastic pipeline-stage registers: state encoding and
// default payload widths (instruction plus next-PC).
package pipe_pkg;

  localparam int INSTR_W = 32;
  localparam int NPC_W   = 32;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } state_t;

endpackage

// File: rtl/pipe_skid_reg_if.sv
// Valid/ready stream bundle. A beat transfers on a clock edge where valid and
// ready are both high; the master holds data stable while valid waits on ready.
interface pipe_skid_reg_if #(
  parameter int DATA_W = 64
);
  logic              valid;
  logic              ready;
  logic [DATA_W-1:0] data;

  modport master (output valid, output data, input ready);
  modport slave  (input valid, input data, output ready);
endinterface

// File: rtl/pipe_skid_reg_sat_counter.sv
// Saturating counter that adds 0..2 per cycle and sticks at its all-ones value.
module sat_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clear,
  input  logic [1:0]   inc,
  output logic [W-1:0] count
);

  logic [W:0] sum;

  // One extra bit is enough to detect overshoot since inc never exceeds 2.
  assign sum = (W+1)'(count) + (W+1)'(inc);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (sum[W]) begin
      count <= '1;
    end else begin
      count <= sum[W-1:0];
    end
  end

endmodule

// File: rtl/pipe_skid_reg.sv
// Two-entry skid pipeline register with registered upstream ready, synchronous
// flush, and a saturating count of flushed payloads.
module pipe_skid_reg
  import pipe_pkg::*;
#(
  parameter int DATA_W = INSTR_W + NPC_W,
  parameter int CNT_W  = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  pipe_skid_reg_if.slave   up,
  pipe_skid_reg_if.master  dn,
  input  logic             flush,
  output logic [CNT_W-1:0] drop_cnt,
  output state_t           state
);

  state_t            state_d;
  logic              ready_q;
  logic              push;
  logic              pop;
  logic              load_m_in;
  logic              load_m_skid;
  logic              load_s;
  logic [1:0]        drop_inc;
  logic [DATA_W-1:0] main_q;
  logic [DATA_W-1:0] skid_q;

  assign push     = up.valid & ready_q;
  assign pop      = dn.valid & dn.ready;
  assign up.ready = ready_q;
  assign dn.valid = (state != EMPTY);
  assign dn.data  = main_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= EMPTY;
      ready_q <= 1'b1;
    end else begin
      state   <= state_d;
      ready_q <= (state_d != TWO);
    end
  end

  always_comb begin
    state_d     = state;
    load_m_in   = 1'b0;
    load_m_skid = 1'b0;
    load_s      = 1'b0;
    drop_inc    = 2'd0;
    if (flush) begin
      state_d = EMPTY;
      // Entries held minus the one completing a pop, plus any accepted push.
      case (state)
        EMPTY:   drop_inc = push ? 2'd1 : 2'd0;
        ONE: begin
          case ({pop, push})
            2'b00:   drop_inc = 2'd1;
            2'b01:   drop_inc = 2'd2;
            2'b10:   drop_inc = 2'd0;
            default: drop_inc = 2'd1;
          endcase
        end
        TWO:     drop_inc = pop ? 2'd1 : 2'd2;
        default: drop_inc = 2'd0;
      endcase
    end else begin
      case (state)
        EMPTY: begin
          if (push) begin
            state_d   = ONE;
            load_m_in = 1'b1;
          end
        end
        ONE: begin
          if (push && !pop) begin
            state_d = TWO;
            load_s  = 1'b1;
          end else if (push && pop) begin
            load_m_in = 1'b1;
          end else if (pop) begin
            state_d = EMPTY;
          end
        end
        TWO: begin
          if (pop) begin
            state_d     = ONE;
            load_m_skid = 1'b1;
          end
        end
        default: state_d = EMPTY;
      endcase
    end
  end

  // Payload registers carry no reset; only the state qualifies them.
  always_ff @(posedge clk) begin
    if (load_m_in) begin
      main_q <= up.data;
    end else if (load_m_skid) begin
      main_q <= skid_q;
    end
    if (load_s) begin
      skid_q <= up.data;
    end
  end

  sat_counter #(
    .W (CNT_W)
  ) u_drop_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .clear (1'b0),
    .inc   (drop_inc),
    .count (drop_cnt)
  );

endmodule

// File: tb/tb_pipe_skid_reg.sv
// Directed bench for pipe_skid_reg: streaming, backpressure, flush accounting,
// counter saturation and asynchronous reset.
module tb_pipe_skid_reg;
  import pipe_pkg::*;

  localparam int DATA_W = 64;
  localparam int CNT_W  = 2;

  logic             clk;
  logic             rst_n;
  logic             flush;
  logic [CNT_W-1:0] drop_cnt;
  state_t           state;
  int               checks;
  int               errors;

  pipe_skid_reg_if #(.DATA_W(DATA_W)) up ();
  pipe_skid_reg_if #(.DATA_W(DATA_W)) dn ();

  pipe_skid_reg #(
    .DATA_W (DATA_W),
    .CNT_W  (CNT_W)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .up       (up.slave),
    .dn       (dn.master),
    .flush    (flush),
    .drop_cnt (drop_cnt),
    .state    (state)
  );

  // Clock: rising edges at 5, 15, 25, ...
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [63:0] d, input logic rdy, input logic fl);
    up.valid = v;
    up.data  = d;
    dn.ready = rdy;
    flush    = fl;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst_n  = 1'b0;
    drive(1'b0, 64'h0, 1'b0, 1'b0);

    // Reset values
    #12;
    chk("rst_out_valid", 64'(dn.valid), 64'd0);
    chk("rst_in_ready",  64'(up.ready), 64'd1);
    chk("rst_drop_cnt",  64'(drop_cnt), 64'd0);
    chk("rst_state",     64'(state),    64'(EMPTY));
    rst_n = 1'b1;
    step();

    // Streaming 1..8 with out_ready high
    for (int i = 1; i <= 8; i++) begin
      drive(1'b1, 64'(i), 1'b1, 1'b0);
      step();
      chk("stream_valid", 64'(dn.valid), 64'd1);
      chk("stream_data",  dn.data,       64'(i));
      chk("stream_ready", 64'(up.ready), 64'd1);
    end
    drive(1'b0, 64'h0, 1'b1, 1'b0);
    step();
    chk("stream_drain", 64'(dn.valid), 64'd0);

    // Backpressure: A, B, C with out_ready low
    drive(1'b1, 64'hA, 1'b0, 1'b0);
    step();
    chk("bp_a_state", 64'(state),    64'(ONE));
    chk("bp_a_ready", 64'(up.ready), 64'd1);
    chk("bp_a_data",  dn.data,       64'hA);
    drive(1'b1, 64'hB, 1'b0, 1'b0);
    step();
    chk("bp_b_state", 64'(state),    64'(TWO));
    chk("bp_b_ready", 64'(up.ready), 64'd0);
    chk("bp_b_data",  dn.data,       64'hA);
    drive(1'b1, 64'hC, 1'b0, 1'b0);
    step();
    chk("bp_stall_state", 64'(state),    64'(TWO));
    chk("bp_stall_data",  dn.data,       64'hA);
    chk("bp_stall_valid", 64'(dn.valid), 64'd1);
    drive(1'b1, 64'hC, 1'b1, 1'b0);
    step();
    chk("bp_pop_a_data",  dn.data,       64'hB);
    chk("bp_pop_a_state", 64'(state),    64'(ONE));
    chk("bp_pop_a_ready", 64'(up.ready), 64'd1);
    step();
    chk("bp_c_data",  dn.data,    64'hC);
    chk("bp_c_state", 64'(state), 64'(ONE));
    drive(1'b0, 64'h0, 1'b1, 1'b0);
    step();
    chk("bp_drain", 64'(dn.valid), 64'd0);

    // Flush in TWO without pop
    drive(1'b1, 64'h11, 1'b0, 1'b0);
    step();
    drive(1'b1, 64'h22, 1'b0, 1'b0);
    step();
    chk("fl2_pre_state", 64'(state), 64'(TWO));
    drive(1'b0, 64'h0, 1'b0, 1'b1);
    step();
    chk("fl2_valid", 64'(dn.valid), 64'd0);
    chk("fl2_drop",  64'(drop_cnt), 64'd2);
    chk("fl2_ready", 64'(up.ready), 64'd1);

    // Flush with push and pop in ONE
    drive(1'b1, 64'h33, 1'b0, 1'b0);
    step();
    drive(1'b1, 64'h44, 1'b1, 1'b1);
    chk("fl1_pop_data",  dn.data,       64'h33);
    chk("fl1_pop_valid", 64'(dn.valid), 64'd1);
    step();
    chk("fl1_state", 64'(state),    64'(EMPTY));
    chk("fl1_drop",  64'(drop_cnt), 64'd3);
    drive(1'b0, 64'h0, 1'b1, 1'b0);
    step();
    chk("fl1_no_44", 64'(dn.valid), 64'd0);

    // Saturation: clear via reset, then five flushes dropping one each
    rst_n = 1'b0;
    #2;
    rst_n = 1'b1;
    chk("sat_cleared", 64'(drop_cnt), 64'd0);
    for (int k = 1; k <= 5; k++) begin
      drive(1'b1, 64'(k), 1'b0, 1'b1);
      step();
      chk("sat_drop", 64'(drop_cnt), (k > 3) ? 64'd3 : 64'(k));
    end
    drive(1'b0, 64'h0, 1'b0, 1'b0);
    step();

    // Asynchronous reset while in TWO
    drive(1'b1, 64'h55, 1'b0, 1'b0);
    step();
    drive(1'b1, 64'h66, 1'b0, 1'b0);
    step();
    drive(1'b0, 64'h0, 1'b0, 1'b0);
    chk("ar_pre_state", 64'(state),    64'(TWO));
    chk("ar_pre_drop",  64'(drop_cnt), 64'd3);
    #2;
    rst_n = 1'b0;
    #1;
    chk("ar_valid", 64'(dn.valid), 64'd0);
    chk("ar_drop",  64'(drop_cnt), 64'd0);
    chk("ar_state", 64'(state),    64'(EMPTY));
    chk("ar_ready", 64'(up.ready), 64'd1);
    #2;
    rst_n = 1'b1;
    drive(1'b1, 64'h77, 1'b1, 1'b0);
    step();
    chk("ar_first_valid", 64'(dn.valid), 64'd1);
    chk("ar_first_data",  dn.data,       64'h77);
    drive(1'b0, 64'h0, 1'b1, 1'b0);
    step();
    chk("ar_drain", 64'(dn.valid), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
